// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line and received-character signals of uart_rx_frame.
// master drives the line (pad side), slave is the receiver.
interface uart_rx_if;
    logic       rx_in;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       rx_busy;
    modport master (output rx_in, input rx_data, rx_valid, parity_err, frame_err, rx_busy);
    modport slave (input rx_in, output rx_data, rx_valid, parity_err, frame_err, rx_busy);
endinterface

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: UART receiver, start + 8 data LSB-first + stop, mid-bit sampling.
// Define UART_RX_PARITY_EN to add an even-parity bit before the stop bit.
module uart_rx_frame #(
    parameter int CLKS_PER_BIT = 16
) (
    input logic     clk,
    input logic     rst,
    uart_rx_if.slave bus
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BRK_WAIT
    } state_t;

    state_t           state;
    logic             rx_m;
    logic             rx_s;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       shreg;
    logic [7:0]       data_q;
    logic             valid_q;
    logic             ferr_q;
    logic             busy_q;
    logic             mid;

    assign mid = (cnt == LAST);

`ifdef UART_RX_PARITY_EN
    logic perr;
    logic perr_q;
    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif
    assign bus.rx_data   = data_q;
    assign bus.rx_valid  = valid_q;
    assign bus.frame_err = ferr_q;
    assign bus.rx_busy   = busy_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m    <= 1'b1;
            rx_s    <= 1'b1;
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            shreg   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr    <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            rx_m    <= bus.rx_in;
            rx_s    <= rx_m;
            valid_q <= 1'b0;
            case (state)
                // IDLE is only ever entered with rx_s high, so a low level here is the falling edge
                IDLE: begin
                    if (!rx_s) begin
                        state  <= START;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                    end
                end
                START: begin
                    if (cnt == HALF) begin
                        cnt    <= '0;
                        idx    <= '0;
                        state  <= rx_s ? IDLE : DATA;
                        busy_q <= ~rx_s;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (mid) begin
                        cnt   <= '0;
                        shreg <= {rx_s, shreg[7:1]};
                        idx   <= idx + 3'd1;
`ifdef UART_RX_PARITY_EN
                        if (idx == 3'd7) state <= PARITY;
`else
                        if (idx == 3'd7) state <= STOP;
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (mid) begin
                        cnt   <= '0;
                        perr  <= rx_s ^ (^shreg);
                        state <= STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (mid) begin
                        cnt     <= '0;
                        valid_q <= 1'b1;
                        data_q  <= shreg;
                        ferr_q  <= ~rx_s;
`ifdef UART_RX_PARITY_EN
                        perr_q  <= perr;
`endif
                        state   <= rx_s ? IDLE : BRK_WAIT;
                        busy_q  <= ~rx_s;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                // a held-low line reports one framing error, then waits for release
                BRK_WAIT: begin
                    if (rx_s) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end
endmodule
